// File: rtl/gabor_pkg.sv
// gabor_pkg: shared orientation codes, default widths and writer FSM states
package gabor_pkg;
  localparam int NUM_ORIENT = 6;
  localparam logic [2:0] ORIENT_30 = 3'd0;
  localparam logic [2:0] ORIENT_60 = 3'd1;
  localparam logic [2:0] ORIENT_90 = 3'd2;
  localparam logic [2:0] ORIENT_120 = 3'd3;
  localparam logic [2:0] ORIENT_150 = 3'd4;
  localparam logic [2:0] ORIENT_180 = 3'd5;
  localparam logic [2:0] ORIENT_MAX = 3'd6;
  localparam int RESULT_WIDTH = 22;
  localparam int PIXEL_WIDTH = 8;
  localparam int PIX_ADDR_WIDTH = 18;
  localparam int IMG_PIXELS = 262144;
  localparam int SCALE_SHIFT = 6;
  typedef enum logic [1:0] {IDLE, WRITE, ADVANCE} state_t;
endpackage

// File: rtl/filtered_image_writer_if.sv
// filtered_image_writer_if: result handshake and filtered-image BRAM write port
interface filtered_image_writer_if import gabor_pkg::*; #(
  parameter int result_width = RESULT_WIDTH,
  parameter int pixel_width = PIXEL_WIDTH,
  parameter int pix_addr_width = PIX_ADDR_WIDTH
);
  logic res_valid;
  logic res_ready;
  logic signed [result_width-1:0] res_30, res_60, res_90, res_120, res_150, res_180;
  logic BRAM_we;
  logic [pix_addr_width+2:0] BRAM_fil_img_addr;
  logic [pixel_width-1:0] BRAM_fil_img_din;
  logic frame_done;
  logic overrun;
  modport master (
    output res_valid, res_30, res_60, res_90, res_120, res_150, res_180,
    input res_ready, BRAM_we, BRAM_fil_img_addr, BRAM_fil_img_din, frame_done, overrun
  );
  modport slave (
    input res_valid, res_30, res_60, res_90, res_120, res_150, res_180,
    output res_ready, BRAM_we, BRAM_fil_img_addr, BRAM_fil_img_din, frame_done, overrun
  );
endinterface

// File: rtl/filtered_image_writer_result_quantizer.sv
// result_quantizer: |res| >> scale_shift, saturated to the pixel range
module result_quantizer import gabor_pkg::*; #(
  parameter int result_width = RESULT_WIDTH,
  parameter int pixel_width = PIXEL_WIDTH,
  parameter int scale_shift = SCALE_SHIFT
) (
  input logic signed [result_width-1:0] res,
  output logic [pixel_width-1:0] pix
);
  localparam logic [result_width:0] PIX_MAX = {{(result_width+1-pixel_width){1'b0}}, {pixel_width{1'b1}}};
  logic [result_width:0] ext, mag, shifted;
  // one extra bit so the most negative input has a representable magnitude
  assign ext = {res[result_width-1], res};
  assign mag = res[result_width-1] ? -ext : ext;
  assign shifted = mag >> scale_shift;
  assign pix = shifted > PIX_MAX ? {pixel_width{1'b1}} : shifted[pixel_width-1:0];
endmodule

// File: rtl/filtered_image_writer.sv
// filtered_image_writer: quantizes six orientation results and writes them to the filtered-image BRAM.
// Define GABOR_MAX_ORIENT_EN to append a seventh write (code 6) holding the max of the six pixels.
module filtered_image_writer import gabor_pkg::*; #(
  parameter int result_width = RESULT_WIDTH,
  parameter int pixel_width = PIXEL_WIDTH,
  parameter int pix_addr_width = PIX_ADDR_WIDTH,
  parameter int img_pixels = IMG_PIXELS,
  parameter int scale_shift = SCALE_SHIFT
) (
  input logic clock,
  input logic reset,
  filtered_image_writer_if.slave bus
);
`ifdef GABOR_MAX_ORIENT_EN
  localparam logic [2:0] LAST = ORIENT_MAX;
  logic [pixel_width-1:0] max_r;
`else
  localparam logic [2:0] LAST = ORIENT_180;
`endif
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [pix_addr_width-1:0] idx, idx_n;
  logic signed [result_width-1:0] cap [NUM_ORIENT];
  logic signed [result_width-1:0] q_in;
  logic [pixel_width-1:0] q_out;
  logic we_r, we_n;
  logic [pix_addr_width+2:0] addr_r, addr_n;
  logic [pixel_width-1:0] din_r, din_n;
  logic overrun_r, last_pix;
  assign last_pix = idx == pix_addr_width'(img_pixels - 1);
  // outputs are registered, so each write's data is quantized one cycle ahead:
  // the live res_30 on accept, then the next captured orientation
  assign q_in = state == IDLE ? bus.res_30 : cap[cnt < ORIENT_180 ? cnt + 3'd1 : 3'd0];
  result_quantizer #(
    .result_width(result_width),
    .pixel_width(pixel_width),
    .scale_shift(scale_shift)
  ) u_quant (
    .res(q_in),
    .pix(q_out)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    we_n = 1'b0;
    addr_n = addr_r;
    din_n = din_r;
    unique case (state)
      IDLE: if (bus.res_valid) begin
        state_n = WRITE;
        cnt_n = ORIENT_30;
        we_n = 1'b1;
        addr_n = {ORIENT_30, idx};
        din_n = q_out;
      end
      WRITE: if (cnt == LAST) state_n = ADVANCE;
      else begin
        cnt_n = cnt + 3'd1;
        we_n = 1'b1;
        addr_n = {cnt_n, idx};
`ifdef GABOR_MAX_ORIENT_EN
        din_n = cnt == ORIENT_180 ? max_r : q_out;
`else
        din_n = q_out;
`endif
      end
      ADVANCE: begin
        state_n = IDLE;
        idx_n = last_pix ? '0 : idx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      we_r <= 1'b0;
      addr_r <= '0;
      din_r <= '0;
      overrun_r <= 1'b0;
      cap <= '{default: '0};
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      we_r <= we_n;
      addr_r <= addr_n;
      din_r <= din_n;
      if (state == IDLE && bus.res_valid)
        cap <= '{bus.res_30, bus.res_60, bus.res_90, bus.res_120, bus.res_150, bus.res_180};
      if (state != IDLE && bus.res_valid) overrun_r <= 1'b1;
    end
  end
`ifdef GABOR_MAX_ORIENT_EN
  always_ff @(posedge clock) begin
    if (reset) max_r <= '0;
    else if (state == IDLE && bus.res_valid) max_r <= q_out;
    else if (state == WRITE && cnt < ORIENT_180) max_r <= q_out > max_r ? q_out : max_r;
  end
`endif
  assign bus.res_ready = state == IDLE;
  assign bus.frame_done = state == ADVANCE && last_pix;
  assign bus.BRAM_we = we_r;
  assign bus.BRAM_fil_img_addr = addr_r;
  assign bus.BRAM_fil_img_din = din_r;
  assign bus.overrun = overrun_r;
endmodule
